// File: rtl/sdpram_be_clr.sv
// ---------------------------------------------------------------------------
// sdpram_be_clr
//   Simple dual-port RAM, single clock: one byte-enabled write port and one
//   read port. The read pipeline has a latency of 1 or 2 cycles and a
//   read-valid strobe. A same-address read/write collision is resolved by
//   BYPASS. After reset a hardware sweep writes INIT_VALUE to every word.
//   While the sweep runs, init_busy is high and all requests are dropped.
//
// Ports
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   wr_en      write request
//   wr_be      byte enables, bit i gates wr_data[8i+7:8i]
//   wr_addr    write address
//   wr_data    write data
//   rd_en      read request
//   rd_addr    read address
//   rd_data    read data, qualified by rd_valid, held otherwise
//   rd_valid   one-cycle strobe per accepted read
//   init_busy  high while the clear sweep runs
//
// Controller states
//   state | meaning
//   CLEAR | sweep writes INIT_VALUE to mem[clr_cnt]; requests are dropped
//   READY | normal read/write service; left only on rst
// ---------------------------------------------------------------------------
module sdpram_be_clr #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    RD_LATENCY = 1,
    parameter bit                    BYPASS     = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [DATA_WIDTH/8-1:0]   wr_be,
    input  logic [ADDR_WIDTH-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic                      rd_en,
    input  logic [ADDR_WIDTH-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_valid,
    output logic                      init_busy
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;

    // Elaboration-time parameter checks
    if ((DATA_WIDTH % 8) != 0) begin : g_err_width
        $error("sdpram_be_clr: DATA_WIDTH must be a multiple of 8");
    end
    if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_err_latency
        $error("sdpram_be_clr: RD_LATENCY must be 1 or 2");
    end

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_cnt;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    wr_acc;
    logic                    rd_acc;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [NBYTES-1:0]       mem_wbe;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   rd_merged;

    logic                    s1_valid;
    logic [DATA_WIDTH-1:0]   s1_data;

    // -----------------------------------------------------------------------
    // Controller: clear sweep, then service. The sweep counter is left at
    // zero after wrapping, so a later reset always starts from address 0.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            init_busy <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
                    if (clr_cnt == '1) begin
                        state     <= READY;
                        init_busy <= 1'b0;
                    end
                end
                READY: begin
                    state     <= READY;
                    init_busy <= 1'b0;
                end
                default: begin
                    state     <= CLEAR;
                    clr_cnt   <= '0;
                    init_busy <= 1'b1;
                end
            endcase
        end
    end

    // Requests count only in READY and never on a reset cycle.
    assign wr_acc = wr_en & (state == READY) & ~rst;
    assign rd_acc = rd_en & (state == READY) & ~rst;

    // -----------------------------------------------------------------------
    // Single physical write port, shared by the sweep and the user port.
    // -----------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        mem_wbe   = wr_be;
        if (!rst) begin
            if (state == CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt;
                mem_wdata = INIT_VALUE;
                mem_wbe   = '1;
            end else begin
                mem_we    = wr_acc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (mem_wbe[b]) begin
                    mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read path. The array read returns the pre-write word, which is the
    // read-first result. In write-first mode, the enabled bytes of a
    // colliding write are merged into the returned word.
    // -----------------------------------------------------------------------
    assign rd_word = mem[rd_addr];

    always_comb begin
        rd_merged = rd_word;
        if (BYPASS && wr_acc && (wr_addr == rd_addr)) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wr_be[b]) begin
                    rd_merged[8*b +: 8] = wr_data[8*b +: 8];
                end
            end
        end
    end

    // Data registers load only on a valid transfer, so rd_data holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_acc;
            if (rd_acc) begin
                s1_data <= rd_merged;
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic                  s2_valid;
        logic [DATA_WIDTH-1:0] s2_data;

        always_ff @(posedge clk) begin
            if (rst) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end

        assign rd_valid = s2_valid;
        assign rd_data  = s2_data;
    end else begin : g_lat1
        assign rd_valid = s1_valid;
        assign rd_data  = s1_data;
    end

endmodule

// File: tb/tb_sdpram_be_clr.sv
// Two instances share one stimulus stream:
//   u_dut_a uses a read latency of 1 and the read-first collision policy.
//   u_dut_b uses a read latency of 2 and the write-first collision policy.
// A word-array reference model runs in the driver. At issue time it pushes
// the expected read result and the cycle it is due into a queue per
// instance. Monitors pop from these queues and compare on the falling edge.
module tb_sdpram_be_clr;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          wr_en;
    logic [NB-1:0] wr_be;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;

    logic [DW-1:0] rd_data_a, rd_data_b;
    logic          rd_valid_a, rd_valid_b;
    logic          init_busy_a, init_busy_b;

    sdpram_be_clr #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1),
        .BYPASS(1'b0), .INIT_VALUE(32'h0)
    ) u_dut_a (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a), .init_busy(init_busy_a)
    );

    sdpram_be_clr #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2),
        .BYPASS(1'b1), .INIT_VALUE(32'h0)
    ) u_dut_b (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .init_busy(init_busy_b)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          qa[$];
    exp_t          qb[$];
    exp_t          ea, eb;
    bit            eva, evb;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    bit            chk_en  = 1'b0;
    logic          exp_busy;
    int            clear_left;
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] last_a, last_b;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    // Drive one cycle of inputs and advance the model to the state after the
    // coming rising edge. This task is called 2 ns after a falling edge.
    task automatic step(input bit r, input bit we, input logic [NB-1:0] be,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input bit re, input logic [AW-1:0] ra);
        logic [DW-1:0] old_w, new_w;
        rst     = r;
        wr_en   = we;
        wr_be   = be;
        wr_addr = wa;
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra;
        if (r) begin
            qa.delete();
            qb.delete();
            last_a     = '0;
            last_b     = '0;
            clear_left = DEPTH;
            exp_busy   = 1'b1;
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        end else if (clear_left > 0) begin
            clear_left--;
            exp_busy = (clear_left != 0);
        end else begin
            exp_busy = 1'b0;
            if (re) begin
                old_w = ref_mem[ra];
                new_w = (we && (wa == ra)) ? merge(old_w, wd, be) : old_w;
                qa.push_back('{old_w, cyc + 1});
                qb.push_back('{new_w, cyc + 2});
            end
            if (we) ref_mem[wa] = merge(ref_mem[wa], wd, be);
        end
        @(negedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
        step(1'b0, 1'b1, be, a, d, 1'b0, '0);
    endtask

    task automatic read(input logic [AW-1:0] a);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, a);
    endtask

    // Issue random requests for the remaining sweep cycles. The model drops them.
    task automatic sweep_with_junk();
        while (clear_left > 0) begin
            step(1'b0, 1'($urandom), 4'($urandom), 6'($urandom), $urandom,
                 1'($urandom), 6'($urandom));
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("init_busy_a", 32'(init_busy_a), 32'(exp_busy));
            eva = (qa.size() > 0) && (qa[0].due <= cyc);
            chk("rd_valid_a", 32'(rd_valid_a), 32'(eva));
            if (eva) begin
                ea = qa.pop_front();
                if (rd_valid_a) chk("rd_data_a", rd_data_a, ea.data);
                last_a = ea.data;
            end else if (!rd_valid_a) begin
                chk("hold_a", rd_data_a, last_a);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("init_busy_b", 32'(init_busy_b), 32'(exp_busy));
            evb = (qb.size() > 0) && (qb[0].due <= cyc);
            chk("rd_valid_b", 32'(rd_valid_b), 32'(evb));
            if (evb) begin
                eb = qb.pop_front();
                if (rd_valid_b) chk("rd_data_b", rd_data_b, eb.data);
                last_b = eb.data;
            end else if (!rd_valid_b) begin
                chk("hold_b", rd_data_b, last_b);
            end
        end
    end

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_be   = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
        @(negedge clk);
        #2;
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
        chk_en = 1'b1;
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);

        // Requests issued during the sweep, including the all-ones write to address 2
        step(1'b0, 1'b1, 4'hF, 6'd2, 32'hFFFF_FFFF, 1'b1, 6'd2);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 6'd2);
        sweep_with_junk();

        // Every word has been cleared
        for (int a = 0; a < DEPTH; a++) read(6'(a));
        idle(3);

        // Byte enables
        write(6'd3, 32'hA5A5_A5A5, 4'hF);
        write(6'd3, 32'h0000_FF00, 4'h2);
        write(6'd4, 32'h1234_5678, 4'h0);
        read(6'd3);
        read(6'd4);
        idle(3);

        // Collision, then a re-read that sees the completed write
        write(6'd5, 32'h1122_3344, 4'hF);
        step(1'b0, 1'b1, 4'h1, 6'd5, 32'h0000_00AA, 1'b1, 6'd5);
        read(6'd5);
        idle(3);

        // Back-to-back reads
        for (int a = 0; a < 8; a++) write(6'(a), 32'(a + 32'h100), 4'hF);
        for (int a = 0; a < 8; a++) read(6'(a));
        idle(4);

        // Random traffic on a small address window, so collisions occur often
        for (int i = 0; i < 400; i++) begin
            step(1'b0, 1'($urandom), 4'($urandom), 6'($urandom_range(0, 7)), $urandom,
                 1'($urandom), 6'($urandom_range(0, 7)));
        end
        idle(4);

        // Reset while a read is in flight
        write(6'd9, 32'hDEAD_BEEF, 4'hF);
        read(6'd9);
        step(1'b1, 1'b0, '0, '0, '0, 1'b1, 6'd9);
        sweep_with_junk();
        read(6'd9);
        read(6'd2);
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
